// File: rtl/locked_register_bank_if.sv
// Bus bundle for locked_register_bank: write/lock controls, read port and status.
// LOCK_VIOLATION_COUNT_EN adds viol_clr / viol_count.
interface locked_register_bank_if #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 2
);
   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic [NUM_REGS-1:0]        lock_req;
   logic                       lock_all;
   logic                       scan_mode;
   logic                       debug_unlocked;
   logic [ADDR_W-1:0]          rd_addr;
   logic [DATA_W-1:0]          rd_data;
   logic [NUM_REGS*DATA_W-1:0] Data_out;
   logic [NUM_REGS-1:0]        lock_status;
   logic                       wr_err;
`ifdef LOCK_VIOLATION_COUNT_EN
   logic                       viol_clr;
   logic [7:0]                 viol_count;
`endif

   modport master (
      output wr_en, wr_addr, wr_data, lock_req, lock_all, scan_mode, debug_unlocked, rd_addr,
      input  rd_data, Data_out, lock_status, wr_err
`ifdef LOCK_VIOLATION_COUNT_EN
      , output viol_clr
      , input  viol_count
`endif
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, lock_req, lock_all, scan_mode, debug_unlocked, rd_addr,
      output rd_data, Data_out, lock_status, wr_err
`ifdef LOCK_VIOLATION_COUNT_EN
      , input  viol_clr
      , output viol_count
`endif
   );
endinterface

// File: rtl/locked_register_bank.sv
// Bank of write-once configuration registers with sticky per-register locks.
// Optional lock-violation counter enabled by LOCK_VIOLATION_COUNT_EN.
module locked_register_bank #(
   parameter int                 NUM_REGS  = 4,
   parameter int                 DATA_W    = 16,
   parameter int                 ADDR_W    = 2,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input logic                    Clk,
   input logic                    reset,
   locked_register_bank_if.slave  bus
);
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] lock_q, lock_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                wr_err_q, wr_err_d;

   logic [NUM_REGS-1:0] lock_eff;
   logic [NUM_REGS-1:0] wr_sel;
   logic                dbg_ovr;
   logic                in_range;
   logic                tgt_locked;
   logic                wr_accept;
   logic                lock_reject;
   logic [NUM_REGS*DATA_W-1:0] data_flat;

   // A lock raised in the same cycle as a write already blocks that write.
   always_comb begin
      lock_eff   = lock_q | bus.lock_req | {NUM_REGS{bus.lock_all}};
      dbg_ovr    = bus.debug_unlocked & ~bus.scan_mode;
      in_range   = ({1'b0, bus.wr_addr} < NUM_REGS_W);
      wr_sel     = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_sel[i] = (bus.wr_addr == ADDR_W'(i));
      end
      tgt_locked  = |(lock_eff & wr_sel);
      wr_accept   = bus.wr_en & in_range & (~tgt_locked | dbg_ovr);
      lock_reject = bus.wr_en & in_range & tgt_locked & ~dbg_ovr;

      lock_d   = lock_eff;
      wr_err_d = bus.wr_en & ~wr_accept;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = (wr_accept && wr_sel[i]) ? bus.wr_data : regs_q[i];
      end

      // Out-of-range read index falls through to zero.
      rd_data_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.rd_addr == ADDR_W'(i)) rd_data_d = regs_q[i];
      end

      data_flat = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         data_flat[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
         lock_q    <= '0;
         rd_data_q <= RESET_VAL;
         wr_err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         lock_q    <= lock_d;
         rd_data_q <= rd_data_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign bus.Data_out    = data_flat;
   assign bus.lock_status = lock_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.wr_err      = wr_err_q;

`ifdef LOCK_VIOLATION_COUNT_EN
   logic [7:0] viol_q, viol_d;

   // Clear beats a simultaneous increment; count saturates at 255.
   always_comb begin
      viol_d = viol_q;
      if (bus.viol_clr)                      viol_d = '0;
      else if (lock_reject && viol_q != 8'hFF) viol_d = viol_q + 8'd1;
   end

   always_ff @(posedge Clk) begin
      if (reset) viol_q <= '0;
      else       viol_q <= viol_d;
   end

   assign bus.viol_count = viol_q;
`else
   logic unused_lock_reject;
   assign unused_lock_reject = lock_reject;
`endif
endmodule

// File: doc/locked_register_bank.md
Name: locked_register_bank

Overview:
Parametrised successor to the single locked register: a bank of NUM_REGS data registers, each DATA_W wide, each with its own sticky lock bit. Used for security-critical configuration (key slots, fuse shadows, region bounds) that firmware programs once and then freezes until reset. Scan mode never opens a locked register. Debug override is allowed only when debug is authenticated and scan is off. Locked-write attempts are reported.

Parameters:
NUM_REGS, 4, number of registers in the bank (1..32)
DATA_W, 16, width of each register in bits
ADDR_W, 2, register index width; must satisfy 2**ADDR_W >= NUM_REGS
RESET_VAL, 0, reset value loaded into every register (DATA_W bits)

Ports:
Clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write request, single-cycle strobe
wr_addr  input  ADDR_W  target register index
wr_data  input  DATA_W  write data
lock_req  input  NUM_REGS  per-register lock request, bit i locks register i
lock_all  input  1  locks every register
scan_mode  input  1  scan/test mode active
debug_unlocked  input  1  authenticated debug session active
rd_addr  input  ADDR_W  read index
rd_data  output  DATA_W  registered read data
Data_out  output  NUM_REGS*DATA_W  flat view of all registers, register i at bits [i*DATA_W +: DATA_W]
lock_status  output  NUM_REGS  current lock bits
wr_err  output  1  one-cycle pulse: write rejected (locked or out of range)

Behaviour:
- Clock and reset: single clock Clk; reset is synchronous and active-high, sampled on the rising edge of Clk only.
- Reset values:
  - all registers = RESET_VAL; lock_status = 0; rd_data = RESET_VAL; wr_err = 0.
  - Reset overrides every other input in the same cycle.
- Lock state:
  - lock_status[i] sets on the edge where lock_req[i]=1 or lock_all=1.
  - Sticky: only reset clears it. No input ever clears a lock bit.
- Write permission for register i:
  - effective_lock = lock_status[i] OR lock_req[i] OR lock_all, evaluated in the current cycle. A lock issued in the same cycle as a write wins, so the write is blocked.
  - debug_override = debug_unlocked AND NOT scan_mode.
  - A write is accepted iff wr_en=1, wr_addr < NUM_REGS, and (NOT effective_lock OR debug_override).
  - scan_mode alone never grants access. scan_mode does not block writes to unlocked registers.
- Write timing: an accepted write updates the register on the same edge; the new value is visible on Data_out in the next cycle.
- Rejected writes:
  - A rejected write leaves the register unchanged.
  - wr_err=1 for exactly the cycle after the rejected request, else 0.
  - Back-to-back rejects give back-to-back wr_err pulses.
  - wr_addr >= NUM_REGS always rejects, whatever the lock and debug state.
- Read path:
  - rd_data = register[rd_addr], registered, 1-cycle latency.
  - rd_addr >= NUM_REGS returns 0.
  - Read-during-write to the same index returns the old value; the new value appears on the following read.
- Reset mid-operation: a write and a reset in the same cycle means reset wins, the register becomes RESET_VAL, and no wr_err is raised.
- Debug override does not clear lock bits; the register stays locked after debug_unlocked drops.
- No combinational path from any input to any output.

Optional Feature:
Macro LOCK_VIOLATION_COUNT_EN.
- Defined:
  - Adds output viol_count (8 bits) and input viol_clr (1 bit).
  - viol_count increments on each rejected write caused by effective_lock. Out-of-range rejects are not counted.
  - Saturates at 255. Clears on reset or when viol_clr=1.
  - If viol_clr and an increment occur in the same cycle, clear wins and the result is 0.
- Not defined: ports absent, no counter logic; all other behaviour identical.

Test Plan:
1. Reset, then write 0xA5A5 to reg 2 (unlocked) -> Data_out reg2 = 0xA5A5 next cycle; read rd_addr=2 -> rd_data=0xA5A5 one cycle later; wr_err stays 0.
2. lock_req=4'b0010, then write 0x1234 to reg 1 -> reg 1 unchanged, wr_err pulses 1 cycle; lock_status=4'b0010; write 0x1111 to reg 0 -> accepted.
3. Same-cycle lock_req[3]=1 with write 0xFFFF to reg 3 -> write blocked, wr_err pulse, lock_status[3]=1.
4. lock_all, then scan_mode=1 with debug_unlocked=0 and a write -> rejected. Then scan_mode=1 with debug_unlocked=1 -> rejected. Then scan_mode=0 with debug_unlocked=1, write 0x00C3 -> accepted, lock bit stays 1.
5. Write to wr_addr=5 with NUM_REGS=4, ADDR_W=3 -> no register changes, wr_err pulse. Read addr 5 -> rd_data=0.
6. Reset asserted on the same edge as an accepted write to reg 0 -> reg 0=RESET_VAL, locks cleared, wr_err=0. With LOCK_VIOLATION_COUNT_EN defined: 300 locked writes -> viol_count=255; viol_clr -> 0.
